// File: rtl/top.sv
// Odd-even transposition sorter for a 256-word window of a 512-word memory.
//
// Sorts dm[32..287] (signed 16-bit) into ascending order in place. Each cycle
// NUM_LANES disjoint neighbour pairs are read, compare-exchanged and written
// back, so a full pass over the window takes 128/NUM_LANES cycles. Passes
// alternate even/odd starting with even; 256 passes sort any input.
//
// Phase register top.pu0.pc.pc:
//   8'h00 start, 8'h10 even pass, 8'h11 odd pass, 8'h1e checkpoint, 8'hff done.
//
// Optional feature macro: SORT_EARLY_EXIT_EN
//   When defined, an even pass followed by an odd pass with zero swaps ends
//   the sort early (the checkpoint phase is still emitted after pass 128).
//
// Ports (top):
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low; dm is never cleared by reset

// One compare-exchange lane: orders a signed pair; equal values stay put.
module cx_lane (
  input  logic        en,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] lo,
  output logic [15:0] hi,
  output logic        swap
);
  assign swap = en && ($signed(a) > $signed(b));
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

// Data memory: register array, combinational read, clocked write, no reset
// so hierarchically preloaded contents survive reset.
module sort_dmem #(
  parameter int NUM_LANES = 4
) (
  input  logic                        clk,
  input  logic [NUM_LANES-1:0][8:0]   addr,
  input  logic [NUM_LANES-1:0]        we,
  input  logic [NUM_LANES-1:0][15:0]  wr_lo,
  input  logic [NUM_LANES-1:0][15:0]  wr_hi,
  output logic [NUM_LANES-1:0][15:0]  rd_lo,
  output logic [NUM_LANES-1:0][15:0]  rd_hi
);
  logic [15:0] dm [0:511];

  always_comb begin
    rd_lo = '0;
    rd_hi = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      rd_lo[l] = dm[addr[l]];
      rd_hi[l] = dm[addr[l] + 9'd1];
    end
  end

  // Lanes always address disjoint pairs, so writes never collide.
  always_ff @(posedge clk)
    for (int l = 0; l < NUM_LANES; l++)
      if (we[l]) begin
        dm[addr[l]]        <= wr_lo[l];
        dm[addr[l] + 9'd1] <= wr_hi[l];
      end
endmodule

// Phase / pass / cycle sequencer.
module sort_pc #(
  parameter int CYCLES = 32,
  parameter int CYC_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             any_swap,
  output logic             busy,
  output logic             odd,
  output logic [CYC_W-1:0] cyc
);
  typedef enum logic [7:0] {
    S_START = 8'h00,
    S_EVEN  = 8'h10,
    S_ODD   = 8'h11,
    S_CKPT  = 8'h1e,
    S_DONE  = 8'hff
  } state_t;

  state_t           pc, pc_nxt;
  logic [CYC_W-1:0] cyc_nxt;
  logic [8:0]       pass, pass_nxt;   // 1-based number of the current pass
  logic             seen, seen_nxt;   // a swap happened in this even+odd pair
  logic             quit, quit_nxt;   // leave via checkpoint straight to done
  logic             last;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pc   <= S_START;
      cyc  <= '0;
      pass <= '0;
      seen <= 1'b0;
      quit <= 1'b0;
    end else begin
      pc   <= pc_nxt;
      cyc  <= cyc_nxt;
      pass <= pass_nxt;
      seen <= seen_nxt;
      quit <= quit_nxt;
    end

  assign last = (cyc == CYC_W'(CYCLES - 1));

  always_comb begin
    pc_nxt   = pc;
    cyc_nxt  = cyc;
    pass_nxt = pass;
    seen_nxt = seen;
    quit_nxt = quit;
    case (pc)
      S_START: begin
        pc_nxt   = S_EVEN;
        cyc_nxt  = '0;
        pass_nxt = 9'd1;
        seen_nxt = 1'b0;
        quit_nxt = 1'b0;
      end
      S_EVEN: begin
        cyc_nxt  = cyc + 1'b1;
        seen_nxt = seen | any_swap;
        if (last) begin
          pc_nxt   = S_ODD;
          cyc_nxt  = '0;
          pass_nxt = pass + 9'd1;
        end
      end
      S_ODD: begin
        cyc_nxt  = cyc + 1'b1;
        seen_nxt = seen | any_swap;
        if (last) begin
          cyc_nxt  = '0;
          pass_nxt = pass + 9'd1;
          seen_nxt = 1'b0;
          if (pass == 9'd256)      pc_nxt = S_DONE;
          else if (pass == 9'd128) pc_nxt = S_CKPT;
          else                     pc_nxt = S_EVEN;
`ifdef SORT_EARLY_EXIT_EN
          if (!(seen | any_swap)) begin
            quit_nxt = 1'b1;
            if (pass != 9'd128) pc_nxt = S_DONE;
          end
`endif
        end
      end
      S_CKPT:  pc_nxt = quit ? S_DONE : S_EVEN;
      default: pc_nxt = S_DONE;
    endcase
  end

  assign busy = (pc == S_EVEN) || (pc == S_ODD);
  assign odd  = (pc == S_ODD);
endmodule

// Processing unit: sequencer, memory and the compare-exchange lanes.
module sort_pu #(
  parameter int NUM_LANES = 4
) (
  input  logic clk,
  input  logic rst
);
  localparam int CYCLES = 128 / NUM_LANES;
  localparam int CYC_W  = $clog2(CYCLES);

  logic                       busy, odd, any_swap;
  logic [CYC_W-1:0]           cyc;
  logic [NUM_LANES-1:0]       en, we;
  logic [NUM_LANES-1:0][8:0]  addr;
  logic [NUM_LANES-1:0][15:0] rd_lo, rd_hi, wr_lo, wr_hi;

  sort_pc #(.CYCLES(CYCLES), .CYC_W(CYC_W)) pc (
    .clk(clk), .rst(rst), .any_swap(any_swap),
    .busy(busy), .odd(odd), .cyc(cyc)
  );

  sort_dmem #(.NUM_LANES(NUM_LANES)) dmem (
    .clk(clk), .addr(addr), .we(we),
    .wr_lo(wr_lo), .wr_hi(wr_hi), .rd_lo(rd_lo), .rd_hi(rd_hi)
  );

  // Pair p of a pass starts at 32 + odd + 2p; the odd pass has only 127
  // pairs, so its last lane slot (287,288) is masked off.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [8:0] p;
    assign p       = 9'(cyc) * 9'(NUM_LANES) + 9'(l);
    assign addr[l] = 9'd32 + {8'd0, odd} + {p[7:0], 1'b0};
    assign en[l]   = busy && (p < (odd ? 9'd127 : 9'd128));
  end

  cx_lane u_lane [NUM_LANES-1:0] (
    .en(en), .a(rd_lo), .b(rd_hi), .lo(wr_lo), .hi(wr_hi), .swap(we)
  );

  assign any_swap = |we;
endmodule

module top (
  input  logic clk,
  input  logic rst
);
  sort_pu #(.NUM_LANES(4)) pu0 (.clk(clk), .rst(rst));
endmodule

// File: tb/tb_top.sv
// Directed bench for the in-place sorter: preloads dm hierarchically, runs
// each case to completion and compares the phase trace and memory contents
// against values computed here.
module tb_top;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ntests = 0;
  int   nfail  = 0;

  logic [15:0] exp_dm [0:511];
  int          done_cyc, ck_first, ck_cnt;
  logic [7:0]  first_pc;

  top dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

`ifdef SORT_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Background pattern outside the sort window.
  task automatic fill_outside();
    for (int i = 0; i < 512; i++)
      if (i < 32 || i > 287) exp_dm[i] = 16'(i * 37) ^ 16'h5a5a;
  endtask

  task automatic load_dut();
    for (int i = 0; i < 512; i++) dut.pu0.dmem.dm[i] = exp_dm[i];
  endtask

  // Reference ordering: plain insertion sort on signed values.
  task automatic sort_exp();
    for (int i = 33; i <= 287; i++) begin
      logic [15:0] v;
      int j;
      v = exp_dm[i];
      j = i - 1;
      while (j >= 32 && $signed(exp_dm[j]) > $signed(v)) begin
        exp_dm[j+1] = exp_dm[j];
        j--;
      end
      exp_dm[j+1] = v;
    end
  endtask

  task automatic release_rst(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_pc_in_rst"}, 32'(dut.pu0.pc.pc), 32'h00);
    rst = 1'b1;
    #1 chk({tag, "_pc_start"}, 32'(dut.pu0.pc.pc), 32'h00);
  endtask

  // Runs until the done phase or the cycle budget; n counts rising edges
  // after reset release.
  task automatic run(input int maxc);
    logic [7:0] v;
    done_cyc = -1; ck_first = -1; ck_cnt = 0; first_pc = 8'hxx;
    for (int n = 1; n <= maxc; n++) begin
      @(posedge clk); #1;
      v = dut.pu0.pc.pc;
      if (n == 1) first_pc = v;
      if (v == 8'h1e) begin
        ck_cnt++;
        if (ck_first < 0) ck_first = n;
      end
      if (v == 8'hff) begin
        done_cyc = n;
        break;
      end
    end
  endtask

  task automatic check_dm(input string tag);
    int bad_in, bad_out;
    bad_in = 0; bad_out = 0;
    for (int i = 0; i < 512; i++)
      if (dut.pu0.dmem.dm[i] !== exp_dm[i]) begin
        if (i >= 32 && i <= 287) bad_in++;
        else bad_out++;
      end
    chk({tag, "_window_bad"}, 32'(bad_in), 32'd0);
    chk({tag, "_outside_bad"}, 32'(bad_out), 32'd0);
  endtask

  task automatic check_hold(input string tag);
    repeat (20) @(posedge clk);
    #1 chk({tag, "_pc_hold"}, 32'(dut.pu0.pc.pc), 32'hff);
    check_dm({tag, "_hold"});
  endtask

  initial begin
    // 1: reversed input, full run, checkpoint timing
    fill_outside();
    for (int i = 0; i < 256; i++) exp_dm[32+i] = 16'(255 - i);
    load_dut();
    for (int i = 0; i < 256; i++) exp_dm[32+i] = 16'(i);
    release_rst("rev");
    run(8500);
    chk("rev_first_pc", 32'(first_pc), 32'h10);
    chk("rev_ckpt_cycle", 32'(ck_first), 32'd4097);
    chk("rev_ckpt_len", 32'(ck_cnt), 32'd1);
    if (EARLY) chk("rev_done_in_time", 32'(done_cyc > 0 && done_cyc <= 8194), 32'd1);
    else       chk("rev_done_cycle", 32'(done_cyc), 32'd8194);
    check_dm("rev");
    check_hold("rev");

    // 2: random signed values with both extremes and duplicates
    rst = 1'b0;
    fill_outside();
    for (int i = 32; i <= 287; i++) exp_dm[i] = 16'($urandom);
    exp_dm[100] = 16'h8000;
    exp_dm[40]  = 16'h7fff;
    exp_dm[200] = 16'h0000;
    exp_dm[201] = 16'h0000;
    exp_dm[250] = 16'hffff;
    load_dut();
    sort_exp();
    release_rst("rnd");
    run(8500);
    chk("rnd_done", 32'(done_cyc > 0 && done_cyc <= 8194), 32'd1);
    chk("rnd_min_at_32", 32'(dut.pu0.dmem.dm[32]), 32'h8000);
    chk("rnd_max_at_287", 32'(dut.pu0.dmem.dm[287]), 32'h7fff);
    check_dm("rnd");

    // 3: already sorted input
    rst = 1'b0;
    fill_outside();
    for (int i = 0; i < 256; i++) exp_dm[32+i] = 16'(i * 100 - 12800);
    load_dut();
    release_rst("srt");
    run(8500);
    if (EARLY) chk("srt_done_cycle", 32'(done_cyc), 32'd65);
    else begin
      chk("srt_done_cycle", 32'(done_cyc), 32'd8194);
      chk("srt_ckpt_cycle", 32'(ck_first), 32'd4097);
    end
    check_dm("srt");

    // 4: reset in the middle of a sort, then restart on partial contents
    rst = 1'b0;
    fill_outside();
    for (int i = 0; i < 256; i++) exp_dm[32+i] = 16'(255 - i);
    load_dut();
    for (int i = 0; i < 256; i++) exp_dm[32+i] = 16'(i);
    release_rst("mid");
    run(1000);
    chk("mid_not_done", 32'(done_cyc), 32'hffffffff);
    rst = 1'b0;
    #1 chk("mid_pc_async_rst", 32'(dut.pu0.pc.pc), 32'h00);
    release_rst("mid2");
    run(8500);
    chk("mid_first_pc", 32'(first_pc), 32'h10);
    chk("mid_ckpt_cycle", 32'(ck_first), 32'd4097);
    if (EARLY) chk("mid_done_in_time", 32'(done_cyc > 0 && done_cyc <= 8194), 32'd1);
    else       chk("mid_done_cycle", 32'(done_cyc), 32'd8194);
    check_dm("mid");

    // 5: all-equal input
    rst = 1'b0;
    fill_outside();
    for (int i = 32; i <= 287; i++) exp_dm[i] = 16'h0005;
    load_dut();
    release_rst("eq");
    run(8500);
    if (EARLY) chk("eq_done_cycle", 32'(done_cyc), 32'd65);
    else       chk("eq_done_cycle", 32'(done_cyc), 32'd8194);
    chk("eq_final_pc", 32'(dut.pu0.pc.pc), 32'hff);
    check_dm("eq");

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have no other ports; all observation is through hierarchy: top.pu0.pc.pc (8-bit phase register), top.pu0.dmem.dm (data array).
REQ-004 SHALL contain exactly one processing unit instance pu0, holding submodules pc and dmem.

Function
REQ-005 SHALL implement dm as unpacked array dm[0:511] of 16-bit words, register-based, readable and writable by hierarchical preload at time 0.
REQ-006 SHALL sort the 256 signed two's-complement words dm[32..287] into ascending signed order in place; other dm entries unchanged.
REQ-007 SHALL use odd-even transposition sort: even pass compares pairs (32+2k, 33+2k), odd pass compares (33+2k, 34+2k), k covering all in-range pairs; swap when lower-address word is signed-greater.
REQ-008 SHALL perform 4 compare-exchange operations per cycle on consecutive pairs, reading and writing dm in the same cycle; one pass takes 32 cycles.
REQ-009 SHALL alternate even/odd passes, starting with even, for 256 passes total.
REQ-010 SHALL encode pc.pc as: 8'h00 start (first cycle after reset release), 8'h10 even pass, 8'h11 odd pass, 8'h1e checkpoint, 8'hff done.
REQ-011 SHALL enter 8'h1e for exactly one cycle after pass 128 completes, then resume with pass 129 (even).
REQ-012 SHALL hold pc.pc = 8'hff and dm frozen after the last pass, until reset.
REQ-013 SHALL complete sorting within 8500 cycles of reset release.
REQ-014 SHALL treat equal values as no-swap; 16'h8000 is the minimum, 16'h7fff the maximum.

Reset
REQ-015 SHALL, while rst=0, force pc.pc to 8'h00 and clear pass/pair counters asynchronously.
REQ-016 SHALL NOT clear or modify dm on reset; preloaded contents survive reset.
REQ-017 SHALL, on reset mid-sort, restart from pass 1 on current dm contents after release.

Configuration
REQ-018 SHALL support macro SORT_EARLY_EXIT_EN: when defined, if an even pass and the following odd pass perform zero swaps, go directly to 8'hff (8'h1e still emitted if pass 128 is reached); when undefined, always run all 256 passes.

Verification
REQ-019 Preload dm[32..287] = 255 down to 0, reset 20 ns -> dm[32+i] = i for all i; pc.pc reaches 8'hff by cycle 8500.
REQ-020 Preload random signed values incl. 16'h8000 and 16'h7fff -> ascending signed order, 16'h8000 at dm[32], 16'h7fff at dm[287]; dm[0..31], dm[288..511] unchanged.
REQ-021 Monitor pc.pc -> value 8'h1e seen for exactly one cycle, 128 passes (≈4096 cycles) after start.
REQ-022 Already-sorted input with SORT_EARLY_EXIT_EN -> pc.pc = 8'hff after 2 passes (≈64 cycles), data unchanged; without macro -> 256 passes run, data unchanged.
REQ-023 Assert rst=0 at cycle 1000, release -> pc.pc = 8'h00, sort restarts, final result correctly sorted.
REQ-024 All-equal input (e.g. 16'h0005) -> no writes change values; final pc.pc = 8'hff.
